// File: rtl/data_bus_arbiter.sv
// Two-master round-robin arbiter for the shared external data bus (tristate data, word address, cs, rw).
// Optional bus locking is compiled in with `define ARB_LOCK_EN (adds m0_lock / m1_lock inputs).
module data_bus_arbiter #(
  parameter int ADDR_W        = 30,
  parameter int DATA_W        = 32,
  parameter int ACCESS_CYCLES = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              m0_req,
  input  logic              m0_rw,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  output logic [DATA_W-1:0] m0_rdata,
  output logic              m0_ack,
  output logic              m0_gnt,
  input  logic              m1_req,
  input  logic              m1_rw,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  output logic [DATA_W-1:0] m1_rdata,
  output logic              m1_ack,
  output logic              m1_gnt,
`ifdef ARB_LOCK_EN
  input  logic              m0_lock,
  input  logic              m1_lock,
`endif
  inout  wire  [DATA_W-1:0] data_bus,
  output logic [ADDR_W-1:0] data_address,
  output logic              data_cs,
  output logic              data_rw
);

  localparam int CNT_W = $clog2(ACCESS_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ACCESS_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACCESS,
    S_ACK
  } state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                last_grant_q;   // also the current owner while not IDLE
  logic [ADDR_W-1:0]   addr_q;
  logic                rw_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [DATA_W-1:0]   rdata0_q, rdata1_q;

  logic                grant_valid;
  logic                grant_sel;
  logic                accept;
  logic                last_beat;

`ifdef ARB_LOCK_EN
  logic                locked_q;
  logic                owner_req;
  logic                sel_lock;

  assign owner_req = last_grant_q ? m1_req : m0_req;
  assign sel_lock  = grant_sel ? m1_lock : m0_lock;
`endif

  // Winner selection, evaluated every cycle but only acted on in IDLE.
  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    grant_valid = 1'b0;
    grant_sel   = 1'b0;
    if (m0_req && m1_req) begin
      grant_valid = 1'b1;
      grant_sel   = ~last_grant_q;
    end else if (m0_req) begin
      grant_valid = 1'b1;
      grant_sel   = 1'b0;
    end else if (m1_req) begin
      grant_valid = 1'b1;
      grant_sel   = 1'b1;
    end
`ifdef ARB_LOCK_EN
    // A locked owner that is still requesting bypasses round-robin.
    if (locked_q && owner_req) begin
      grant_valid = 1'b1;
      grant_sel   = last_grant_q;
    end
`endif
  end

  assign accept    = (state_q == S_IDLE) && grant_valid;
  assign last_beat = (state_q == S_ACCESS) && (cnt_q == CNT_LAST);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      S_IDLE: begin
        if (grant_valid) begin
          state_d = S_ACCESS;
          cnt_d   = '0;
        end
      end
      S_ACCESS: begin
        if (cnt_q == CNT_LAST) begin
          state_d = S_ACK;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_ACK: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      last_grant_q <= 1'b1;
      addr_q       <= '0;
      rw_q         <= 1'b0;
      wdata_q      <= '0;
      rdata0_q     <= '0;
      rdata1_q     <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) begin
        last_grant_q <= grant_sel;
        addr_q       <= grant_sel ? m1_addr  : m0_addr;
        rw_q         <= grant_sel ? m1_rw    : m0_rw;
        wdata_q      <= grant_sel ? m1_wdata : m0_wdata;
      end
      if (last_beat && !rw_q) begin
        if (last_grant_q) begin
          rdata1_q <= data_bus;
        end else begin
          rdata0_q <= data_bus;
        end
      end
    end
  end

`ifdef ARB_LOCK_EN
  // Lock is re-latched from the winner on every accept and dropped when an idle owner stops requesting.
  always_ff @(posedge clk) begin
    if (reset) begin
      locked_q <= 1'b0;
    end else if (state_q == S_IDLE) begin
      locked_q <= grant_valid && sel_lock;
    end
  end
`endif

  assign data_cs      = (state_q == S_ACCESS);
  assign data_rw      = data_cs && rw_q;
  assign data_address = addr_q;
  assign data_bus     = (data_cs && rw_q) ? wdata_q : {DATA_W{1'bz}};

  assign m0_gnt   = (state_q != S_IDLE) && !last_grant_q;
  assign m1_gnt   = (state_q != S_IDLE) &&  last_grant_q;
  assign m0_ack   = (state_q == S_ACK)  && !last_grant_q;
  assign m1_ack   = (state_q == S_ACK)  &&  last_grant_q;
  assign m0_rdata = rdata0_q;
  assign m1_rdata = rdata1_q;

endmodule

// File: tb/tb_data_bus_arbiter.sv
// Directed bench for data_bus_arbiter: one instance with ACCESS_CYCLES=1 (a_*), one with ACCESS_CYCLES=3 (b_*).
// Lock scenario runs only when ARB_LOCK_EN is defined.
module tb_data_bus_arbiter;

  localparam int AW = 30;
  localparam int DW = 32;
  localparam logic [DW-1:0] BUS_Z = 32'hFFFF_FFFF;  // pulled-up idle bus

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  logic          rst_a, rst_b;
  logic          a_m0_req, a_m0_rw, a_m1_req, a_m1_rw;
  logic [AW-1:0] a_m0_addr, a_m1_addr;
  logic [DW-1:0] a_m0_wdata, a_m1_wdata, a_m0_rdata, a_m1_rdata;
  logic          a_m0_ack, a_m0_gnt, a_m1_ack, a_m1_gnt;
  tri1  [DW-1:0] a_bus;
  logic [AW-1:0] a_addr;
  logic          a_cs, a_rw;
  logic [DW-1:0] a_mem;
  logic [7:0]    console;

  logic          b_m0_req, b_m0_rw, b_m1_req, b_m1_rw;
  logic [AW-1:0] b_m0_addr, b_m1_addr;
  logic [DW-1:0] b_m0_wdata, b_m1_wdata, b_m0_rdata, b_m1_rdata;
  logic          b_m0_ack, b_m0_gnt, b_m1_ack, b_m1_gnt;
  tri1  [DW-1:0] b_bus;
  logic [AW-1:0] b_addr;
  logic          b_cs, b_rw;
  logic [DW-1:0] b_mem;

`ifdef ARB_LOCK_EN
  logic a_m0_lock, a_m1_lock, b_m0_lock, b_m1_lock;
`endif

  data_bus_arbiter #(.ADDR_W(AW), .DATA_W(DW), .ACCESS_CYCLES(1)) u_dut_a (
    .clk(clk), .reset(rst_a),
    .m0_req(a_m0_req), .m0_rw(a_m0_rw), .m0_addr(a_m0_addr), .m0_wdata(a_m0_wdata),
    .m0_rdata(a_m0_rdata), .m0_ack(a_m0_ack), .m0_gnt(a_m0_gnt),
    .m1_req(a_m1_req), .m1_rw(a_m1_rw), .m1_addr(a_m1_addr), .m1_wdata(a_m1_wdata),
    .m1_rdata(a_m1_rdata), .m1_ack(a_m1_ack), .m1_gnt(a_m1_gnt),
`ifdef ARB_LOCK_EN
    .m0_lock(a_m0_lock), .m1_lock(a_m1_lock),
`endif
    .data_bus(a_bus), .data_address(a_addr), .data_cs(a_cs), .data_rw(a_rw)
  );

  data_bus_arbiter #(.ADDR_W(AW), .DATA_W(DW), .ACCESS_CYCLES(3)) u_dut_b (
    .clk(clk), .reset(rst_b),
    .m0_req(b_m0_req), .m0_rw(b_m0_rw), .m0_addr(b_m0_addr), .m0_wdata(b_m0_wdata),
    .m0_rdata(b_m0_rdata), .m0_ack(b_m0_ack), .m0_gnt(b_m0_gnt),
    .m1_req(b_m1_req), .m1_rw(b_m1_rw), .m1_addr(b_m1_addr), .m1_wdata(b_m1_wdata),
    .m1_rdata(b_m1_rdata), .m1_ack(b_m1_ack), .m1_gnt(b_m1_gnt),
`ifdef ARB_LOCK_EN
    .m0_lock(b_m0_lock), .m1_lock(b_m1_lock),
`endif
    .data_bus(b_bus), .data_address(b_addr), .data_cs(b_cs), .data_rw(b_rw)
  );

  // Memory models answer reads; console is the character byte [15:8] of a write to word 0.
  assign a_bus = (a_cs && !a_rw) ? a_mem : {DW{1'bz}};
  assign b_bus = (b_cs && !b_rw) ? b_mem : {DW{1'bz}};

  always @(posedge clk) begin
    if (a_cs && a_rw && (a_addr == '0)) console <= a_bus[15:8];
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int order [8];
  int when  [8];
  int n_ack;
  int m1_done;

  initial begin
    rst_a = 1'b1; rst_b = 1'b1;
    {a_m0_req, a_m0_rw, a_m1_req, a_m1_rw} = '0;
    {b_m0_req, b_m0_rw, b_m1_req, b_m1_rw} = '0;
    a_m0_addr = '0; a_m1_addr = '0; a_m0_wdata = '0; a_m1_wdata = '0;
    b_m0_addr = '0; b_m1_addr = '0; b_m0_wdata = '0; b_m1_wdata = '0;
    a_mem = '0; b_mem = '0; console = '0;
`ifdef ARB_LOCK_EN
    {a_m0_lock, a_m1_lock, b_m0_lock, b_m1_lock} = '0;
`endif
    repeat (2) tick();

    check("rst_cs",    a_cs, 0);
    check("rst_rw",    a_rw, 0);
    check("rst_addr",  a_addr, 0);
    check("rst_flags", {a_m0_ack, a_m1_ack, a_m0_gnt, a_m1_gnt}, 0);
    check("rst_rdata", a_m0_rdata, 0);
    check("rst_bus",   a_bus, BUS_Z);
    check("rst_b_cs",  b_cs, 0);
    rst_a = 1'b0; rst_b = 1'b0;

    // Single read from master 0
    a_m0_req = 1'b1; a_m0_rw = 1'b0; a_m0_addr = 30'h10; a_mem = 32'hDEAD_BEEF;
    tick();
    check("rd_cs",   a_cs, 1);
    check("rd_rw",   a_rw, 0);
    check("rd_addr", a_addr, 32'h10);
    check("rd_gnt0", a_m0_gnt, 1);
    check("rd_ack0_early", a_m0_ack, 0);
    tick();
    check("rd_cs_off", a_cs, 0);
    check("rd_ack0",   a_m0_ack, 1);
    check("rd_rdata",  a_m0_rdata, 32'hDEAD_BEEF);
    check("rd_ack1",   a_m1_ack, 0);
    a_m0_req = 1'b0;
    tick();
    check("rd_ack0_pulse", a_m0_ack, 0);
    check("rd_cs_idle",    a_cs, 0);

    // Console write from master 1
    a_m1_req = 1'b1; a_m1_rw = 1'b1; a_m1_addr = '0; a_m1_wdata = 32'h0000_4100;
    check("wr_bus_pre", a_bus, BUS_Z);
    tick();
    check("wr_bus",  a_bus, 32'h0000_4100);
    check("wr_rw",   a_rw, 1);
    check("wr_addr", a_addr, 0);
    check("wr_gnt1", a_m1_gnt, 1);
    tick();
    check("wr_ack1",     a_m1_ack, 1);
    check("wr_ack0",     a_m0_ack, 0);
    check("wr_bus_post", a_bus, BUS_Z);
    check("wr_console",  console, 8'h41);
    check("wr_rdata1",   a_m1_rdata, 0);
    a_m1_req = 1'b0;
    tick();
    check("wr_ack1_pulse", a_m1_ack, 0);

    // Contention from reset: both masters read continuously
    rst_a = 1'b1;
    a_m0_req = 1'b1; a_m0_rw = 1'b0; a_m0_addr = 30'h1;
    a_m1_req = 1'b1; a_m1_rw = 1'b0; a_m1_addr = 30'h2;
    tick();
    rst_a = 1'b0;
    n_ack = 0;
    for (int i = 0; i < 8; i++) begin order[i] = -1; when[i] = -1; end
    for (int c = 1; c <= 24; c++) begin
      tick();
      if (a_m0_ack || a_m1_ack) begin
        if (n_ack < 8) begin
          order[n_ack] = a_m1_ack ? 1 : 0;
          when[n_ack]  = c;
        end
        n_ack++;
      end
    end
    a_m0_req = 1'b0; a_m1_req = 1'b0;
    check("cont_acks", n_ack, 8);
    check("cont_first_ack", when[0], 2);
    for (int i = 0; i < 8; i++) check($sformatf("cont_order%0d", i), order[i], i % 2);
    for (int i = 1; i < 8; i++) check($sformatf("cont_gap%0d", i), when[i] - when[i-1], 3);
    tick();

    // Latency with ACCESS_CYCLES=3: only the last-beat bus value is captured
    b_m0_req = 1'b1; b_m0_rw = 1'b0; b_m0_addr = 30'h20;
    tick();
    b_mem = 32'h1111_1111;
    check("lat_cs1", b_cs, 1);
    tick();
    b_mem = 32'h2222_2222;
    check("lat_cs2", b_cs, 1);
    check("lat_ack_early", b_m0_ack, 0);
    tick();
    b_mem = 32'h3333_3333;
    check("lat_cs3", b_cs, 1);
    tick();
    check("lat_cs_off", b_cs, 0);
    check("lat_ack",    b_m0_ack, 1);
    check("lat_rdata",  b_m0_rdata, 32'h3333_3333);
    b_m0_req = 1'b0;
    tick();
    check("lat_ack_pulse", b_m0_ack, 0);

    // Reset during the second ACCESS cycle of a write
    b_m0_req = 1'b1; b_m0_rw = 1'b1; b_m0_addr = 30'h5; b_m0_wdata = 32'hCAFE_F00D;
    tick();
    check("abort_bus", b_bus, 32'hCAFE_F00D);
    tick();
    rst_b = 1'b1;
    tick();
    check("abort_cs",    b_cs, 0);
    check("abort_ack",   {b_m0_ack, b_m1_ack}, 0);
    check("abort_gnt",   {b_m0_gnt, b_m1_gnt}, 0);
    check("abort_bus_z", b_bus, BUS_Z);
    check("abort_rdata", b_m0_rdata, 0);
    b_m0_rw = 1'b0; b_m1_req = 1'b1; b_m1_rw = 1'b0; b_m1_addr = 30'h7;
    b_mem = 32'h5A5A_5A5A;
    rst_b = 1'b0;
    tick();
    check("after_gnt0", b_m0_gnt, 1);
    check("after_gnt1", b_m1_gnt, 0);
    repeat (3) tick();
    check("after_ack0",  b_m0_ack, 1);
    check("after_ack1",  b_m1_ack, 0);
    check("after_rdata", b_m0_rdata, 32'h5A5A_5A5A);
    b_m0_req = 1'b0; b_m1_req = 1'b0;
    tick();

`ifdef ARB_LOCK_EN
    // Master 1 holds a lock for three transfers while master 0 waits
    a_m1_req = 1'b1; a_m1_lock = 1'b1; a_m1_rw = 1'b0;
    n_ack = 0; m1_done = 0;
    for (int i = 0; i < 8; i++) order[i] = -1;
    for (int c = 0; c < 16 && n_ack < 4; c++) begin
      tick();
      if (a_m1_gnt) a_m0_req = 1'b1;
      if (a_m0_ack || a_m1_ack) begin
        order[n_ack] = a_m1_ack ? 1 : 0;
        n_ack++;
        if (a_m1_ack) begin
          m1_done++;
          if (m1_done == 2) a_m1_lock = 1'b0;
          if (m1_done == 3) a_m1_req = 1'b0;
        end
        if (a_m0_ack) a_m0_req = 1'b0;
      end
    end
    a_m0_req = 1'b0; a_m1_req = 1'b0;
    check("lock_acks", n_ack, 4);
    check("lock_order0", order[0], 1);
    check("lock_order1", order[1], 1);
    check("lock_order2", order[2], 1);
    check("lock_order3", order[3], 0);
    repeat (2) tick();
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/data_bus_arbiter.md
Name: data_bus_arbiter

Overview:
- Two-master arbiter for the CPU's external data bus: data_bus (tristate 32-bit), data_address (30-bit word address), data_cs, data_rw.
- Master 0 is the MIPS_CPU data port; master 1 is a secondary master (program loader/DMA).
- Serialises their transfers with a request/ack handshake and round-robin priority.
- Drives the single shared bus to memory and memory-mapped I/O, including the console port at word address 0.

Parameters:
- ADDR_W, 30, word-address width.
- DATA_W, 32, data width.
- ACCESS_CYCLES, 1, cycles data_cs is held per transfer; must be >= 1; counter width is $clog2(ACCESS_CYCLES+1).

Ports:
- clk  in  1  system clock, all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- m0_req  in  1  master 0 transfer request, held until m0_ack.
- m0_rw  in  1  1 = write, 0 = read.
- m0_addr  in  ADDR_W  word address.
- m0_wdata  in  DATA_W  write data.
- m0_rdata  out  DATA_W  read data, valid while m0_ack = 1.
- m0_ack  out  1  one-cycle completion pulse.
- m0_gnt  out  1  master 0 owns the bus (ACCESS/ACK states).
- m1_req, m1_rw, m1_addr, m1_wdata, m1_rdata, m1_ack, m1_gnt: same as the m0_* ports, for master 1.
- data_bus  inout  DATA_W  shared bus; driven only during write access, else high-Z.
- data_address  out  ADDR_W  bus word address.
- data_cs  out  1  bus chip select.
- data_rw  out  1  1 = write, 0 = read.

Behaviour:
- Reset values: data_cs=0, data_rw=0, data_address=0, data_bus=Z, mX_ack=0, mX_gnt=0, mX_rdata=0, state=IDLE, cnt=0, last_grant=1 (master 0 wins the first contention).
- FSM states: IDLE, ACCESS, ACK.
- IDLE:
  - Requests are sampled. If none, stay in IDLE.
  - If exactly one master requests, grant it.
  - If both request, grant the master != last_grant.
  - On grant: latch winner's addr/rw/wdata into bus registers, set last_grant=winner, cnt=0, go to ACCESS.
- ACCESS:
  - data_cs=1; data_address and data_rw come from latched values.
  - data_bus driven with latched wdata only when rw=1, otherwise Z.
  - cnt increments each cycle. On the cycle where cnt==ACCESS_CYCLES-1:
    - sample data_bus into winner's rdata register (read only; rdata unchanged on write);
    - go to ACK.
- ACK:
  - data_cs=0, bus released; winner's ack=1 for exactly this cycle.
  - Next state is IDLE.
- Timing:
  - Request accepted in IDLE cycle N.
  - data_cs high in cycles N+1 .. N+ACCESS_CYCLES.
  - ack in cycle N+ACCESS_CYCLES+1.
  - Minimum spacing between accepts is ACCESS_CYCLES+2.
- Master obligation: hold req and request fields stable until ack. Any req still high in the IDLE cycle after ACK is a new transfer.
- Request changes during ACCESS/ACK are ignored; fields are latched at accept.
- Non-granted master's ack stays 0 and its rdata is held.
- Simultaneous requests alternate strictly: with both held continuously, grants go 0,1,0,1…
- Reset asserted mid-ACCESS or mid-ACK:
  - next edge returns to IDLE with all reset values;
  - no ack is issued for the aborted transfer; data_bus goes Z.
- Address 0 gets no special treatment; console writes are ordinary writes.

Optional Feature:
- Macro ARB_LOCK_EN adds inputs m0_lock and m1_lock.
- With the macro:
  - The lock bit of the winner is latched at accept into locked/owner.
  - In IDLE with locked=1 and owner req=1: grant the owner regardless of the other master and re-latch locked from owner's lock.
  - In IDLE with locked=1 and owner req=0: clear locked and arbitrate normally in the same cycle.
  - Reset clears locked.
- Without the macro: no lock ports, pure round-robin.

Test Plan:
- Single read: m0 read addr 0x10, memory model returns 0xDEADBEEF with ACCESS_CYCLES=1 -> data_cs high exactly 1 cycle, data_rw=0, data_address=0x10, m0_ack on following cycle with m0_rdata=0xDEADBEEF, m1_ack stays 0.
- Write/console: m1 writes 0x00004100 to addr 0 -> data_bus=0x00004100 only while data_cs=1, Z otherwise, m1_ack one cycle, console model sees 'A'.
- Contention: m0 and m1 both request continuously from reset, 4 transfers each -> grant order 0,1,0,1…, each ack one cycle, accepts 3 cycles apart.
- Latency: ACCESS_CYCLES=3, m0 read -> data_cs high 3 cycles, ack at accept+4, rdata sampled in last cs cycle (bus value changed each cycle; only the third value captured).
- Reset mid-op: assert reset in 2nd ACCESS cycle (ACCESS_CYCLES=3) -> data_cs=0 next edge, no ack, data_bus Z; next request after reset completes normally with master 0 winning contention.
- ARB_LOCK_EN: m1 requests with lock=1 for 3 transfers while m0 requests throughout -> m1 granted 3 times back-to-back, then m0 granted once m1 drops lock.
